// File: rtl/tlp_fifo_wr_arbiter_pkg.sv
// Shared definitions for the fragmentation datapath: FSM state encodings and
// TLP FIFO sizing constants used by the write arbiter.
package Fragmentation_Package;

  localparam int TLP_FIFO_DEPTH  = 256;
  localparam int NO_LOC_WR_WIDTH = 4;
  localparam int COUNT_WIDTH     = 9;
  localparam int MAX_NO_LOC      = 9;

  typedef enum logic [1:0] {
    FRAG_IDLE = 2'd0,
    FRAG_HDR  = 2'd1,
    FRAG_DATA = 2'd2
  } frag_state_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/tlp_fifo_wr_arbiter_picker.sv
// Combinational round-robin picker: scans the request mask starting at index
// 'start' and returns the first set bit as a one-hot vector.
module rr_priority_picker #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  int idx;

  always_comb begin
    pick = '0;
    any  = 1'b0;
    idx  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(start) + k) % NUM_REQ;
      if (!any && req[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlp_fifo_wr_arbiter.sv
// Round-robin arbiter granting whole TLPs into the shared TLP FIFO only when
// enough free locations exist; tracks free space from writes and pops.
module tlp_fifo_wr_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int NO_LOC_WR_WIDTH = Fragmentation_Package::NO_LOC_WR_WIDTH,
  parameter int COUNT_WIDTH     = Fragmentation_Package::COUNT_WIDTH
) (
  input  logic                               clk,
  input  logic                               arst,
  input  logic [NUM_REQ-1:0]                 i_req,
  input  logic [NUM_REQ*NO_LOC_WR_WIDTH-1:0] i_no_loc,
  input  logic                               i_fifo_rd_en,
  output logic [NUM_REQ-1:0]                 o_grant,
  output logic                               o_fifo_wr_en,
  output logic [NO_LOC_WR_WIDTH-1:0]         o_fifo_no_loc_wr,
  output logic [COUNT_WIDTH-1:0]             o_free_loc,
  output logic [NUM_REQ-1:0]                 o_size_err,
  output logic [1:0]                         o_state
);

  import Fragmentation_Package::arb_state_t;
  import Fragmentation_Package::ARB_IDLE;
  import Fragmentation_Package::ARB_GRANT;
  import Fragmentation_Package::ARB_WAIT;
  import Fragmentation_Package::MAX_NO_LOC;
  import Fragmentation_Package::TLP_FIFO_DEPTH;

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [COUNT_WIDTH-1:0]     FULL_FREE = COUNT_WIDTH'(TLP_FIFO_DEPTH);
  localparam logic [NO_LOC_WR_WIDTH-1:0] MAX_LOC   = NO_LOC_WR_WIDTH'(MAX_NO_LOC);

  arb_state_t                 state;
  logic [IDX_W-1:0]           winner;
  logic [IDX_W-1:0]           rr_ptr;
  logic                       rr_valid;
  logic                       just_granted;
  logic [NO_LOC_WR_WIDTH-1:0] win_loc;
  logic [COUNT_WIDTH-1:0]     free_cnt;
  logic [NUM_REQ-1:0]         size_err;

  logic [NO_LOC_WR_WIDTH-1:0] loc [NUM_REQ];
  logic [NUM_REQ-1:0]         illegal;
  logic [NUM_REQ-1:0]         arb_mask;
  logic [NUM_REQ-1:0]         legal;
  logic [IDX_W-1:0]           start;
  logic [NUM_REQ-1:0]         pick;
  logic                       any;
  logic [IDX_W-1:0]           pick_idx;
  logic [NO_LOC_WR_WIDTH-1:0] pick_loc;
  logic [NO_LOC_WR_WIDTH-1:0] held_loc;
  logic [COUNT_WIDTH-1:0]     wr_amt;
  logic                       rd_ok;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_loc
    assign loc[g]     = i_no_loc[g*NO_LOC_WR_WIDTH +: NO_LOC_WR_WIDTH];
    assign illegal[g] = (loc[g] == '0) || (loc[g] > MAX_LOC);
  end

  // The requester granted last cycle sits out the following idle cycle.
  assign arb_mask = just_granted ? (NUM_REQ'(1) << rr_ptr) : '0;
  assign legal    = i_req & ~illegal & ~arb_mask;
  assign start    = !rr_valid ? '0 :
                    (rr_ptr == IDX_W'(NUM_REQ - 1)) ? '0 : rr_ptr + IDX_W'(1);

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (legal),
    .start (start),
    .pick  (pick),
    .any   (any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) pick_idx = IDX_W'(i);
    end
  end

  assign pick_loc = loc[pick_idx];
  assign held_loc = loc[winner];

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state        <= ARB_IDLE;
      winner       <= '0;
      rr_ptr       <= '0;
      rr_valid     <= 1'b0;
      just_granted <= 1'b0;
      win_loc      <= '0;
      size_err     <= '0;
    end else begin
      just_granted <= (state == ARB_GRANT);
      size_err     <= (state == ARB_IDLE) ? (i_req & illegal) : '0;
      case (state)
        ARB_IDLE: begin
          if (any) begin
            winner  <= pick_idx;
            win_loc <= pick_loc;
            state   <= (COUNT_WIDTH'(pick_loc) <= free_cnt) ? ARB_GRANT : ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          // The latched winner is never bypassed; it either fits or withdraws.
          if (!i_req[winner]) begin
            state <= ARB_IDLE;
          end else if (COUNT_WIDTH'(held_loc) <= free_cnt) begin
            win_loc <= held_loc;
            state   <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          rr_ptr   <= winner;
          rr_valid <= 1'b1;
          state    <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign wr_amt = o_fifo_wr_en ? COUNT_WIDTH'(o_fifo_no_loc_wr) : '0;
  assign rd_ok  = i_fifo_rd_en && (free_cnt != FULL_FREE);

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      free_cnt <= FULL_FREE;
    end else begin
      free_cnt <= free_cnt - wr_amt + COUNT_WIDTH'(rd_ok);
    end
  end

  assign o_fifo_wr_en     = (state == ARB_GRANT);
  assign o_grant          = o_fifo_wr_en ? (NUM_REQ'(1) << winner) : '0;
  assign o_fifo_no_loc_wr = o_fifo_wr_en ? win_loc : '0;
  assign o_free_loc       = free_cnt;
  assign o_size_err       = size_err;
  assign o_state          = state;

endmodule

// File: tb/tb_tlp_fifo_wr_arbiter.sv
// Directed bench for the TLP FIFO write arbiter: grant timing, round-robin
// order, space waiting, free-count accounting, size errors and async reset.
module tb_tlp_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        arst;
  logic [2:0]  i_req;
  logic [11:0] i_no_loc;
  logic        i_fifo_rd_en;
  logic [2:0]  o_grant;
  logic        o_fifo_wr_en;
  logic [3:0]  o_fifo_no_loc_wr;
  logic [8:0]  o_free_loc;
  logic [2:0]  o_size_err;
  logic [1:0]  o_state;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  tlp_fifo_wr_arbiter dut (
    .clk              (clk),
    .arst             (arst),
    .i_req            (i_req),
    .i_no_loc         (i_no_loc),
    .i_fifo_rd_en     (i_fifo_rd_en),
    .o_grant          (o_grant),
    .o_fifo_wr_en     (o_fifo_wr_en),
    .o_fifo_no_loc_wr (o_fifo_no_loc_wr),
    .o_free_loc       (o_free_loc),
    .o_size_err       (o_size_err),
    .o_state          (o_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] n);
    i_req[i] = 1'b1;
    i_no_loc[i*4 +: 4] = n;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b0;
    i_req = '0;
    i_no_loc = '0;
    i_fifo_rd_en = 1'b0;
    repeat (2) @(negedge clk);
    arst = 1'b1;
  endtask

  // Requests one TLP and returns on the negedge where its grant is visible.
  task automatic grant_one(input int i, input logic [3:0] n);
    logic seen;
    seen = 1'b0;
    set_req(i, n);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_grant[i]) begin
        seen = 1'b1;
        break;
      end
    end
    i_req[i] = 1'b0;
    check("grant_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    arst = 1'b0;
    i_req = '0;
    i_no_loc = '0;
    i_fifo_rd_en = 1'b0;
    #12;
    check("rst_free", 32'(o_free_loc), 32'd256);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("rst_no_loc", 32'(o_fifo_no_loc_wr), 32'd0);
    check("rst_size_err", 32'(o_size_err), 32'd0);
    check("rst_state", 32'(o_state), 32'd0);
    @(negedge clk);
    arst = 1'b1;

    // Pop on an empty FIFO must not raise the free count past 256.
    i_fifo_rd_en = 1'b1;
    @(negedge clk);
    i_fifo_rd_en = 1'b0;
    check("empty_pop_free", 32'(o_free_loc), 32'd256);

    // Single posted request of 9 locations.
    set_req(0, 4'd9);
    @(negedge clk);
    check("single_grant", 32'(o_grant), 32'b001);
    check("single_wr_en", 32'(o_fifo_wr_en), 32'd1);
    check("single_no_loc", 32'(o_fifo_no_loc_wr), 32'd9);
    i_req = '0;
    @(negedge clk);
    check("single_free", 32'(o_free_loc), 32'd247);
    check("single_idle_grant", 32'(o_grant), 32'd0);
    check("single_idle_wr", 32'(o_fifo_wr_en), 32'd0);

    // Round-robin across three continuous requesters of 1 location.
    do_reset();
    for (int k = 0; k < 6; k++) exp_q.push_back(3'b001 << (k % 3));
    set_req(0, 4'd1);
    set_req(1, 4'd1);
    set_req(2, 4'd1);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c % 2 == 1) check("rr_grant", 32'(o_grant), 32'(exp_q.pop_front()));
      else            check("rr_gap", 32'(o_grant), 32'd0);
    end
    i_req = '0;
    @(negedge clk);
    check("rr_free", 32'(o_free_loc), 32'd250);

    // Bring free space down to 5, then a 9-location winner must wait.
    do_reset();
    for (int k = 0; k < 27; k++) grant_one(2, 4'd9);
    grant_one(2, 4'd8);
    set_req(0, 4'd9);
    set_req(1, 4'd1);
    repeat (2) @(negedge clk);
    check("wait_state", 32'(o_state), 32'd2);
    check("wait_free", 32'(o_free_loc), 32'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("wait_no_grant", 32'(o_grant), 32'd0);
    end
    i_fifo_rd_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("wait_rd_no_grant", 32'(o_grant), 32'd0);
    end
    i_fifo_rd_en = 1'b0;
    check("wait_free_9", 32'(o_free_loc), 32'd9);
    @(negedge clk);
    check("wait_grant", 32'(o_grant), 32'b001);
    check("wait_grant_loc", 32'(o_fifo_no_loc_wr), 32'd9);
    i_req[0] = 1'b0;
    @(negedge clk);
    check("wait_free_0", 32'(o_free_loc), 32'd0);
    @(negedge clk);
    check("req1_waits", 32'(o_state), 32'd2);
    check("req1_no_grant", 32'(o_grant), 32'd0);
    i_req[1] = 1'b0;
    @(negedge clk);
    check("withdraw_idle", 32'(o_state), 32'd0);
    check("withdraw_no_grant", 32'(o_grant), 32'd0);
    check("withdraw_no_err", 32'(o_size_err), 32'd0);

    // Grant of 4 coinciding with a pop at free = 100.
    do_reset();
    for (int k = 0; k < 17; k++) grant_one(2, 4'd9);
    grant_one(2, 4'd3);
    grant_one(0, 4'd4);
    check("rw_free_before", 32'(o_free_loc), 32'd100);
    check("rw_no_loc", 32'(o_fifo_no_loc_wr), 32'd4);
    i_fifo_rd_en = 1'b1;
    @(negedge clk);
    i_fifo_rd_en = 1'b0;
    check("rw_free_after", 32'(o_free_loc), 32'd97);

    // Illegal size on requester 1, legal on requester 2.
    do_reset();
    set_req(1, 4'd0);
    set_req(2, 4'd5);
    @(negedge clk);
    check("err_flag", 32'(o_size_err), 32'b010);
    check("err_grant", 32'(o_grant), 32'b100);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("err_never_r1", 32'(o_grant[1]), 32'd0);
      check("err_bits_02", 32'(o_size_err & 3'b101), 32'd0);
    end
    i_req = '0;

    // Size above 9 is also illegal.
    do_reset();
    set_req(0, 4'd10);
    @(negedge clk);
    check("err10_flag", 32'(o_size_err), 32'b001);
    check("err10_grant", 32'(o_grant), 32'd0);
    i_req = '0;

    // Asynchronous reset in the middle of a grant.
    do_reset();
    grant_one(0, 4'd2);
    #2 arst = 1'b0;
    #1;
    check("arst_grant", 32'(o_grant), 32'd0);
    check("arst_wr_en", 32'(o_fifo_wr_en), 32'd0);
    check("arst_no_loc", 32'(o_fifo_no_loc_wr), 32'd0);
    check("arst_free", 32'(o_free_loc), 32'd256);
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    check("arst_free_after", 32'(o_free_loc), 32'd256);
    check("arst_state_after", 32'(o_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
